rom_arbiter: RTL
================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter SIZE, default 'h2000, ROM depth in words (J1 code space).
REQ-002 Parameter ADDR_WIDTH, default $clog2(SIZE), address width of all ports.
REQ-003 Parameter DATA_WIDTH, default 16, data width of all ports.
REQ-004 Port clock  input  1  single clock, all logic on posedge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port f_req  input  1  fetch port read request, level, re-evaluated each cycle.
REQ-007 Port f_addr  input  ADDR_WIDTH  fetch word address.
REQ-008 Port f_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-009 Port f_valid  output  1  fetch data valid (registered).
REQ-010 Port f_data  output  DATA_WIDTH  fetch read data.
REQ-011 Ports wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone classic slave controls.
REQ-012 Port wb_adr_i  input  ADDR_WIDTH  Wishbone word address.
REQ-013 Port wb_dat_o  output  DATA_WIDTH  Wishbone read data.
REQ-014 Ports wb_ack_o, wb_err_o  output  1 each  Wishbone termination.
REQ-015 Ports rom_address  output  ADDR_WIDTH, rom_cen  output  1, rom_q  input  DATA_WIDTH  connection to the synchronous ROM (one-cycle registered read, enabled by cen).

Function
REQ-016 Each cycle at most one requester is granted; rom_cen=1 and rom_address=granted address in that same cycle (combinational), else rom_cen=0, rom_address=0.
REQ-017 Fetch eligible whenever f_req=1; fetch may be granted every cycle (throughput 1/cycle).
REQ-018 Wishbone eligible only when wb_cyc_i & wb_stb_i & !wb_we_i and WB FSM is WB_IDLE.
REQ-019 WB FSM states WB_IDLE, WB_ACK, WB_ERR; WB_IDLE->WB_ACK on WB grant; WB_IDLE->WB_ERR on cyc&stb&we; WB_ACK and WB_ERR -> WB_IDLE unconditionally after one cycle.
REQ-020 f_valid=1 exactly one cycle after f_gnt=1; f_data=rom_q when f_valid=1, else 0.
REQ-021 wb_ack_o = (state==WB_ACK) & wb_cyc_i; wb_dat_o=rom_q when wb_ack_o=1, else 0; read latency 1 cycle from grant.
REQ-022 wb_err_o = (state==WB_ERR) & wb_cyc_i; writes never assert rom_cen.
REQ-023 stb held high during WB_ACK/WB_ERR is not re-granted; next WB grant earliest two cycles after previous grant.
REQ-024 wb_cyc_i dropped while in WB_ACK: ack suppressed, FSM still returns to WB_IDLE, ROM read discarded.
REQ-025 Simultaneous eligible requests resolved per Configuration; the loser's request is held by its master and served later, nothing is queued internally.
REQ-026 Addresses >= SIZE are passed unchanged (upper bits truncate per ROM); no error.

Reset
REQ-027 reset_n=0 asynchronously forces WB FSM to WB_IDLE, f_valid=0, priority pointer to fetch, all outputs 0.
REQ-028 Reset during a pending access drops its f_valid/wb_ack_o; no response is issued after release.
REQ-029 First grant possible in the first clock edge after reset_n rises.

Configuration
REQ-030 Macro ROM_ARB_ROUND_ROBIN_EN defined: on conflict grant the requester not granted in the most recent conflict; pointer updates only on conflict cycles.
REQ-031 Macro undefined: fixed priority, fetch always wins; Wishbone served only in cycles with f_req=0.

Structure
REQ-032 Package rom_arb_pkg SHALL hold the WB FSM state enum and the requester-id typedef (FETCH, WB).
REQ-033 Sub-module rom_arb_rr SHALL implement the two-way arbitration (fixed or round-robin per macro); rom_arbiter holds FSM and response registers.

Verification
REQ-034 f_req=1, f_addr=0x0010 for 3 cycles, ROM holds 0x6000+addr -> f_gnt 3 cycles, f_valid 3 cycles one cycle later, f_data 0x6010 each.
REQ-035 WB read adr 0x0123, no fetch -> rom_cen one cycle, wb_ack_o one cycle later with wb_dat_o=0x6123, stb held -> no second grant in ack cycle.
REQ-036 WB write adr 0x0005 -> wb_err_o=1 one cycle after, rom_cen never asserted.
REQ-037 f_req and WB read both continuous for 6 cycles: macro undefined -> WB never acked; macro defined -> WB granted on alternating conflicts, ack data correct.
REQ-038 reset_n pulled low the cycle after a WB grant -> wb_ack_o never asserts, all outputs 0 during reset, normal grant on first edge after release.
REQ-039 wb_cyc_i dropped in WB_ACK cycle -> wb_ack_o=0, FSM back in WB_IDLE, next read acked normally.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM arbiter: Wishbone slave FSM states and requester ids.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_ACK  = 2'd1,
        WB_ERR  = 2'd2
    } wb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        WB    = 1'b1
    } req_id_e;

endpackage

// File: rtl/rom_arb_rr.sv
// Two-way grant logic between the fetch port and the Wishbone port.
// ROM_ARB_ROUND_ROBIN_EN selects round-robin on conflicts; otherwise fetch always wins.
module rom_arb_rr
    import rom_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic f_elig_i,
    input  logic wb_elig_i,
    output logic f_gnt_o,
    output logic wb_gnt_o
);

    req_id_e prio_q, prio_d;
    logic    conflict;

    assign conflict = f_elig_i & wb_elig_i;

    always_comb begin
        f_gnt_o  = 1'b0;
        wb_gnt_o = 1'b0;
        if (conflict) begin
            f_gnt_o  = (prio_q == FETCH);
            wb_gnt_o = (prio_q == WB);
        end else begin
            f_gnt_o  = f_elig_i;
            wb_gnt_o = wb_elig_i;
        end
    end

    // Without round-robin the pointer never leaves FETCH, giving fixed priority.
    always_comb begin
        prio_d = prio_q;
`ifdef ROM_ARB_ROUND_ROBIN_EN
        if (conflict) begin
            prio_d = (prio_q == FETCH) ? WB : FETCH;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= FETCH;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM between a fetch port and a read-only Wishbone slave.
// Conflict policy set by ROM_ARB_ROUND_ROBIN_EN (see rom_arb_rr).
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned SIZE       = 'h2000,
    parameter int unsigned ADDR_WIDTH = $clog2(SIZE),
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_valid,
    output logic [DATA_WIDTH-1:0] f_data,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_cen,
    input  logic [DATA_WIDTH-1:0] rom_q
);

    wb_state_e state_q, state_d;
    logic      f_valid_q;
    logic      f_elig, wb_elig, wb_gnt, wb_wr;

    // Eligibility is gated by reset so no grant leaks out while reset is held.
    assign f_elig  = reset_n & f_req;
    assign wb_wr   = wb_cyc_i & wb_stb_i & wb_we_i;
    assign wb_elig = reset_n & wb_cyc_i & wb_stb_i & ~wb_we_i & (state_q == WB_IDLE);

    rom_arb_rr u_rr (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .f_elig_i  (f_elig),
        .wb_elig_i (wb_elig),
        .f_gnt_o   (f_gnt),
        .wb_gnt_o  (wb_gnt)
    );

    always_comb begin
        rom_cen     = f_gnt | wb_gnt;
        rom_address = '0;
        if (f_gnt) begin
            rom_address = f_addr;
        end else if (wb_gnt) begin
            rom_address = wb_adr_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WB_IDLE: begin
                if (wb_gnt) begin
                    state_d = WB_ACK;
                end else if (wb_wr) begin
                    state_d = WB_ERR;
                end
            end
            WB_ACK:  state_d = WB_IDLE;
            WB_ERR:  state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= WB_IDLE;
            f_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            f_valid_q <= f_gnt;
        end
    end

    // A dropped cyc in WB_ACK suppresses the ack; the ROM word is simply discarded.
    assign f_valid  = f_valid_q;
    assign f_data   = f_valid_q ? rom_q : '0;
    assign wb_ack_o = (state_q == WB_ACK) & wb_cyc_i;
    assign wb_err_o = (state_q == WB_ERR) & wb_cyc_i;
    assign wb_dat_o = wb_ack_o ? rom_q : '0;

endmodule
